fp_reg_file: RTL and testbench
==============================

# fp_reg_file

Parametrised floating-point co-processor register file with integrated, registered read-port selection. It replaces the fixed 16-entry, four-output combinational select with:
- a configurable number of registers, width and read ports;
- two prioritised write ports, fed by the ALU result and the SRAM load;
- same-cycle write-to-read bypass;
- a per-register pending (busy) scoreboard used by the controller to stall dependent operations.

## Interface
Parameters:
- DATA_W, 32, register and data-bus width in bits
- NUM_REGS, 16, number of registers (2..256; need not be a power of two)
- SEL_W, 4, register-select width; NUM_REGS must be at most 2^SEL_W
- NUM_RD, 4, number of read ports (port 0 DataOut, 1 operand1, 2 operand2, 3 SRAM read in the default build)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- wr_en_a  in  1  write port A enable (ALU result, high priority)
- wr_sel_a  in  SEL_W  port A destination register
- wr_data_a  in  DATA_W  port A data
- wr_en_b  in  1  write port B enable (SRAM load, low priority)
- wr_sel_b  in  SEL_W  port B destination register
- wr_data_b  in  DATA_W  port B data
- lock_en  in  1  mark lock_sel pending (operation issued, result outstanding)
- lock_sel  in  SEL_W  register to mark pending
- rd_en  in  NUM_RD  per-port read request
- rd_sel  in  NUM_RD*SEL_W  packed selects; port i occupies bits [i*SEL_W +: SEL_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port flag: rd_data[i] is committed (non-pending) data
- busy  out  NUM_REGS  per-register pending flags
- sel_err  out  1  one-cycle pulse flagging an out-of-range select used last cycle

## Operation
- **Storage:** NUM_REGS × DATA_W flops. All registers reset to 0.
- **Writes:**
  - On a rising edge, write ports A and B update their destination registers.
  - If both target the same register, port A's data is stored and port B is dropped.
  - A write with sel ≥ NUM_REGS is ignored.
- **Reads (per port i, independent):**
  - If rd_en[i] is high at an edge, rd_data[i] loads the selected value. Otherwise rd_data[i] holds its previous value.
  - **Bypass:** if a write to the same register occurs in that same cycle, rd_data[i] loads the winning write data, not the stale register contents.
  - An out-of-range select loads 0.
- **rd_valid[i]:**
  - Registered. Set to rd_en[i] AND (the select is in range) AND (the register is not busy, OR the register is written in the same cycle and not re-locked).
  - Cleared when rd_en[i] is low.
- **Scoreboard:**
  - lock_en sets busy[lock_sel].
  - Any write (A or B, including a dropped B write) clears busy on its destination.
  - Lock and write to the same register in the same cycle: busy ends set, because the lock represents a new producer. The data write still occurs.
- **sel_err:** registered OR of any *enabled* select (wr_a, wr_b, lock, any rd_en port) that is ≥ NUM_REGS. It is a pulse and is not sticky.
- **Parameter and width rules:**
  - Selects are compared unsigned against NUM_REGS.
  - When NUM_REGS = 2^SEL_W, sel_err is constant 0.

## Timing
- **Reset:** asynchronous; takes effect immediately on n_rst low. Outputs during reset:
  - all registers, rd_data and busy = 0;
  - rd_valid = 0;
  - sel_err = 0.
- **Read latency:** one cycle from rd_en/rd_sel to rd_data/rd_valid. There is no combinational path from any input to any output.
- **Write-to-read:** a write in cycle N is visible on a read issued in cycle N via bypass, so rd_data is correct in N+1.
- **Lock timing:** lock in cycle N makes busy high from N+1. A read issued in cycle N still gets rd_valid = 1 if the register was not busy before N.
- **Reset mid-operation:** all pending state is lost, and busy bits and data return to 0. There is no partial write.

## Test plan
- **Reset:** assert n_rst low mid-cycle with nonzero contents. Required: immediately rd_data = 0, busy = 0, rd_valid = 0, sel_err = 0.
- **Basic write/read:** write 0x3F800000 to reg 5 via A, then next cycle rd_en[1], rd_sel[1] = 5. Required: rd_data[1] = 0x3F800000 and rd_valid[1] = 1 one cycle later.
- **Port collision and bypass:** in one cycle, A writes 0x40000000 to reg 7, B writes 0xC0000000 to reg 7, and port 0 reads reg 7. Required:
  - next cycle rd_data[0] = 0x40000000;
  - a later read of reg 7 returns 0x40000000.
- **Scoreboard:**
  - lock reg 3, then read reg 3 → rd_valid = 0, busy[3] = 1;
  - B writes 0x12345678 to reg 3 while port 2 reads it → rd_data[2] = 0x12345678, rd_valid[2] = 1, busy[3] = 0;
  - lock and write reg 3 in the same cycle → busy[3] stays 1.
- **Out-of-range select (NUM_REGS = 12):**
  - read sel 13 → rd_data = 0, rd_valid = 0, sel_err pulses one cycle;
  - write sel 14 → no register changes, sel_err pulses.
- **Parallel reads:** all four ports read regs 0, 1, 2, 15 with distinct contents in one cycle. Required: each port returns its own value. A port with rd_en low holds its prior rd_data.

Source files
------------

// File: rtl/fp_reg_file.sv
// fp_reg_file: parametrised FP co-processor register file.
// Two prioritised write ports, bypassed registered reads, busy scoreboard.
module fp_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4,
    parameter int NUM_RD   = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     wr_en_a,
    input  logic [SEL_W-1:0]         wr_sel_a,
    input  logic [DATA_W-1:0]        wr_data_a,
    input  logic                     wr_en_b,
    input  logic [SEL_W-1:0]         wr_sel_b,
    input  logic [DATA_W-1:0]        wr_data_b,
    input  logic                     lock_en,
    input  logic [SEL_W-1:0]         lock_sel,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     sel_err
);

    function automatic logic in_rng(input logic [SEL_W-1:0] s);
        return 32'(s) < 32'(NUM_REGS);
    endfunction

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic                     sel_err_q, sel_err_d;

    logic a_ok, b_ok, l_ok, b_win;

    // Out-of-range writes and locks are ignored; B loses a same-target clash.
    assign a_ok  = wr_en_a && in_rng(wr_sel_a);
    assign b_ok  = wr_en_b && in_rng(wr_sel_b);
    assign l_ok  = lock_en && in_rng(lock_sel);
    assign b_win = b_ok && !(a_ok && (wr_sel_a == wr_sel_b));

    // Storage and scoreboard next state; a lock outranks a clearing write.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            busy_d[r] = busy_q[r];
            if (b_win && (wr_sel_b == SEL_W'(r)))
                regs_d[r] = wr_data_b;
            if (a_ok && (wr_sel_a == SEL_W'(r)))
                regs_d[r] = wr_data_a;
            if ((a_ok && (wr_sel_a == SEL_W'(r))) ||
                (b_ok && (wr_sel_b == SEL_W'(r))))
                busy_d[r] = 1'b0;
            if (l_ok && (lock_sel == SEL_W'(r)))
                busy_d[r] = 1'b1;
        end
    end

    // Read ports with same-cycle write bypass, plus select error detection.
    always_comb begin : rd_comb
        logic [SEL_W-1:0]  s;
        logic [DATA_W-1:0] v;
        logic              bz;
        logic              hit;
        logic              relock;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        sel_err_d  = (wr_en_a && !in_rng(wr_sel_a)) ||
                     (wr_en_b && !in_rng(wr_sel_b)) ||
                     (lock_en && !in_rng(lock_sel));
        for (int i = 0; i < NUM_RD; i++) begin
            s  = rd_sel[i*SEL_W +: SEL_W];
            v  = '0;
            bz = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (SEL_W'(r) == s) begin
                    v  = regs_q[r];
                    bz = busy_q[r];
                end
            end
            hit = (a_ok && (wr_sel_a == s)) ||
                  (b_ok && (wr_sel_b == s));
            if (a_ok && (wr_sel_a == s))
                v = wr_data_a;
            else if (b_win && (wr_sel_b == s))
                v = wr_data_b;
            relock = l_ok && (lock_sel == s);
            if (rd_en[i]) begin
                if (in_rng(s)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = v;
                    rd_valid_d[i] = !bz || (hit && !relock);
                end else begin
                    rd_data_d[i*DATA_W +: DATA_W] = '0;
                    sel_err_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset clears data, scoreboard and read outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= '0;
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= regs_d[r];
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_fp_reg_file.sv
// tb_fp_reg_file: directed plus random checks of fp_reg_file
// against an array-based reference model, for 16- and 12-entry builds.
module tb_fp_reg_file;

    logic         clk;
    logic         n_rst;
    logic         wr_en_a, wr_en_b, lock_en;
    logic [3:0]   wr_sel_a, wr_sel_b, lock_sel;
    logic [31:0]  wr_data_a, wr_data_b;
    logic [3:0]   rd_en;
    logic [15:0]  rd_sel;

    logic [127:0] rd_data_0, rd_data_1;
    logic [3:0]   rd_valid_0, rd_valid_1;
    logic [15:0]  busy_0;
    logic [11:0]  busy_1;
    logic         sel_err_0, sel_err_1;

    int tests = 0;
    int fails = 0;

    logic [31:0]  m_mem  [2][16];
    logic [15:0]  m_busy [2];
    logic [127:0] m_rd   [2];
    logic [3:0]   m_val  [2];
    logic         m_err  [2];

    fp_reg_file u_dut (
        .clk(clk), .n_rst(n_rst),
        .wr_en_a(wr_en_a), .wr_sel_a(wr_sel_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_sel_b(wr_sel_b), .wr_data_b(wr_data_b),
        .lock_en(lock_en), .lock_sel(lock_sel),
        .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data_0), .rd_valid(rd_valid_0),
        .busy(busy_0), .sel_err(sel_err_0)
    );

    fp_reg_file #(.NUM_REGS(12)) u_dut12 (
        .clk(clk), .n_rst(n_rst),
        .wr_en_a(wr_en_a), .wr_sel_a(wr_sel_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_sel_b(wr_sel_b), .wr_data_b(wr_data_b),
        .lock_en(lock_en), .lock_sel(lock_sel),
        .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data_1), .rd_valid(rd_valid_1),
        .busy(busy_1), .sel_err(sel_err_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) m_mem[k][r] = '0;
            m_busy[k] = '0;
            m_rd[k]   = '0;
            m_val[k]  = '0;
            m_err[k]  = 1'b0;
        end
    endtask

    // One clock edge of the behavioural model for both builds.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          n;
            logic        aok, bok, lok, err, wrote, relock;
            logic [31:0] nm [16];
            logic [3:0]  s;
            n   = (k == 0) ? 16 : 12;
            aok = wr_en_a && (wr_sel_a < n);
            bok = wr_en_b && (wr_sel_b < n);
            lok = lock_en && (lock_sel < n);
            err = (wr_en_a && !aok) || (wr_en_b && !bok) || (lock_en && !lok);
            for (int r = 0; r < 16; r++) nm[r] = m_mem[k][r];
            if (bok) nm[wr_sel_b] = wr_data_b;
            if (aok) nm[wr_sel_a] = wr_data_a;
            for (int i = 0; i < 4; i++) begin
                s = rd_sel[i*4 +: 4];
                m_val[k][i] = 1'b0;
                if (rd_en[i]) begin
                    if (s >= n) begin
                        m_rd[k][i*32 +: 32] = '0;
                        err = 1'b1;
                    end else begin
                        m_rd[k][i*32 +: 32] = nm[s];
                        wrote  = (aok && wr_sel_a == s) || (bok && wr_sel_b == s);
                        relock = lok && lock_sel == s;
                        m_val[k][i] = !m_busy[k][s] || (wrote && !relock);
                    end
                end
            end
            if (aok) m_busy[k][wr_sel_a] = 1'b0;
            if (bok) m_busy[k][wr_sel_b] = 1'b0;
            if (lok) m_busy[k][lock_sel] = 1'b1;
            for (int r = 0; r < 16; r++) m_mem[k][r] = nm[r];
            m_err[k] = err;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/u16 rd_data"},  rd_data_0,  m_rd[0]);
        chk({tag, "/u16 rd_valid"}, 128'(rd_valid_0), 128'(m_val[0]));
        chk({tag, "/u16 busy"},     128'(busy_0),     128'(m_busy[0]));
        chk({tag, "/u16 sel_err"},  128'(sel_err_0),  128'(m_err[0]));
        chk({tag, "/u12 rd_data"},  rd_data_1,  m_rd[1]);
        chk({tag, "/u12 rd_valid"}, 128'(rd_valid_1), 128'(m_val[1]));
        chk({tag, "/u12 busy"},     128'(busy_1),     128'(m_busy[1][11:0]));
        chk({tag, "/u12 sel_err"},  128'(sel_err_1),  128'(m_err[1]));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (n_rst) model_step();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        wr_en_a = 1'b0; wr_en_b = 1'b0; lock_en = 1'b0; rd_en = '0;
    endtask

    task automatic set_rd(input int p, input logic [3:0] s);
        rd_en[p] = 1'b1;
        rd_sel[p*4 +: 4] = s;
    endtask

    initial begin
        n_rst = 1'b0;
        wr_sel_a = '0; wr_sel_b = '0; lock_sel = '0;
        wr_data_a = '0; wr_data_b = '0; rd_sel = '0;
        idle();
        model_reset();
        #1;
        check_all("reset");
        cycle("reset_hold");
        n_rst = 1'b1;

        // basic write then read
        wr_en_a = 1'b1; wr_sel_a = 4'd5; wr_data_a = 32'h3F80_0000;
        cycle("wr5");
        idle(); set_rd(1, 4'd5);
        cycle("rd5");
        chk("basic rd1", 128'(rd_data_0[63:32]), 128'(32'h3F80_0000));
        chk("basic val1", 128'(rd_valid_0[1]), 128'(1'b1));

        // collision plus bypass
        idle();
        wr_en_a = 1'b1; wr_sel_a = 4'd7; wr_data_a = 32'h4000_0000;
        wr_en_b = 1'b1; wr_sel_b = 4'd7; wr_data_b = 32'hC000_0000;
        set_rd(0, 4'd7);
        cycle("collide");
        chk("bypass rd0", 128'(rd_data_0[31:0]), 128'(32'h4000_0000));
        idle(); set_rd(0, 4'd7);
        cycle("reread7");
        chk("later rd7", 128'(rd_data_0[31:0]), 128'(32'h4000_0000));

        // scoreboard
        idle(); lock_en = 1'b1; lock_sel = 4'd3;
        cycle("lock3");
        chk("busy3 set", 128'(busy_0[3]), 128'(1'b1));
        idle(); set_rd(0, 4'd3);
        cycle("rd_busy3");
        chk("busy rd invalid", 128'(rd_valid_0[0]), 128'(1'b0));
        idle();
        wr_en_b = 1'b1; wr_sel_b = 4'd3; wr_data_b = 32'h1234_5678;
        set_rd(2, 4'd3);
        cycle("wrb3");
        chk("wb bypass rd2", 128'(rd_data_0[95:64]), 128'(32'h1234_5678));
        chk("wb val2", 128'(rd_valid_0[2]), 128'(1'b1));
        chk("busy3 clr", 128'(busy_0[3]), 128'(1'b0));
        idle();
        lock_en = 1'b1; lock_sel = 4'd3;
        wr_en_a = 1'b1; wr_sel_a = 4'd3; wr_data_a = 32'h0BAD_F00D;
        cycle("lockwr3");
        chk("lock wins", 128'(busy_0[3]), 128'(1'b1));

        // out-of-range selects on the 12-entry build
        idle(); set_rd(0, 4'd13);
        cycle("oor_rd");
        chk("oor rd data", 128'(rd_data_1[31:0]), 128'(0));
        chk("oor rd err", 128'(sel_err_1), 128'(1'b1));
        idle();
        cycle("oor_idle");
        chk("err pulse", 128'(sel_err_1), 128'(1'b0));
        wr_en_a = 1'b1; wr_sel_a = 4'd14; wr_data_a = 32'hDEAD_BEEF;
        cycle("oor_wr");
        chk("oor wr err", 128'(sel_err_1), 128'(1'b1));

        // parallel reads
        idle();
        wr_en_a = 1'b1; wr_sel_a = 4'd0; wr_data_a = 32'hA0A0_0000;
        wr_en_b = 1'b1; wr_sel_b = 4'd1; wr_data_b = 32'hB1B1_1111;
        cycle("par_w1");
        wr_sel_a = 4'd2; wr_data_a = 32'hC2C2_2222;
        wr_sel_b = 4'd15; wr_data_b = 32'hDFDF_FFFF;
        cycle("par_w2");
        idle();
        set_rd(0, 4'd0); set_rd(1, 4'd1); set_rd(2, 4'd2); set_rd(3, 4'd15);
        cycle("par_rd");
        chk("par all", rd_data_0,
            {32'hDFDF_FFFF, 32'hC2C2_2222, 32'hB1B1_1111, 32'hA0A0_0000});
        idle(); set_rd(0, 4'd5);
        cycle("par_hold");
        chk("par hold", 128'(rd_data_0[127:32]),
            128'({32'hDFDF_FFFF, 32'hC2C2_2222, 32'hB1B1_1111}));

        // asynchronous reset mid-cycle with nonzero contents
        #3;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        cycle("rst_hold");
        n_rst = 1'b1;
        idle(); set_rd(0, 4'd5);
        cycle("post_rst");

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            wr_en_a   = ($urandom_range(0, 2) != 0);
            wr_sel_a  = 4'($urandom_range(0, 15));
            wr_data_a = $urandom;
            wr_en_b   = ($urandom_range(0, 1) != 0);
            wr_sel_b  = ($urandom_range(0, 3) == 0) ? wr_sel_a
                                                    : 4'($urandom_range(0, 15));
            wr_data_b = $urandom;
            lock_en   = ($urandom_range(0, 3) == 0);
            lock_sel  = 4'($urandom_range(0, 15));
            rd_en     = 4'($urandom);
            rd_sel    = 16'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
